// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single backing memory: IDLE->ISSUE->WAIT->RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-port priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t            state;
  logic [7:0]        cnt;
  logic              sel_dm;
  logic              we_lat;
  logic              grant_dm;
  logic [DATA_W-1:0] rd_val;

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_dm;
  assign grant_dm = dm_req_i & (~if_req_i | prio_dm);
`else
  assign grant_dm = dm_req_i;
`endif

  // a timeout completes with zero read data
  assign rd_val  = mem_ack_i ? mem_rdata_i : '0;
  assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      sel_dm      <= 1'b0;
      we_lat      <= 1'b0;
      if_rdata_o  <= '0;
      if_ack_o    <= 1'b0;
      dm_rdata_o  <= '0;
      dm_ack_o    <= 1'b0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      err_o       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      prio_dm     <= 1'b1;
`endif
    end else begin
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      err_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req_i | dm_req_i) begin
            sel_dm      <= grant_dm;
            we_lat      <= grant_dm & dm_we_i;
            mem_en_o    <= 1'b1;
            mem_we_o    <= grant_dm & dm_we_i;
            mem_addr_o  <= grant_dm ? dm_addr_i : if_addr_i;
            mem_wdata_o <= grant_dm ? dm_wdata_i : '0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_dm     <= ~grant_dm;
`endif
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en_o <= 1'b0;
          mem_we_o <= 1'b0;
          cnt      <= 8'd1;
          state    <= WAIT;
        end
        WAIT: begin
          if (mem_ack_i || cnt == TO) begin
            if (sel_dm) begin
              dm_ack_o <= 1'b1;
              if (!we_lat) dm_rdata_o <= rd_val;
            end else begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= rd_val;
            end
            err_o <= ~mem_ack_i;
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions, then arbitration and reset sequences.
module tb_mem_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, dm_req_i, dm_we_i, mem_ack_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ack_o, dm_ack_o, mem_en_o, mem_we_o, stall_o, err_o;

  int n_chk = 0;
  int n_pass = 0;
  int order_q[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;      // cycles after the mem_en_o cycle that mem_ack_i is driven
    logic [31:0] mrd;
    int          exp_cyc;  // cycles from request to ack
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic run_txn(input int idx, input vec_t t);
    int en_c, en_n, ack_c;
    logic we_s, got_dm, err_s, stall_s;
    logic [31:0] addr_s, wd_s, rd_s;
    string p;
    p = $sformatf("v%0d_", idx);
    en_c = -1; en_n = 0; ack_c = -1;
    we_s = 0; got_dm = 0; err_s = 0; stall_s = 0; addr_s = 0; wd_s = 0; rd_s = 0;
    if_req_i = !t.is_dm; dm_req_i = t.is_dm; dm_we_i = t.we;
    if_addr_i = t.addr; dm_addr_i = t.addr; dm_wdata_i = t.wdata; mem_rdata_i = t.mrd;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk_i); #1;
      if (mem_en_o) begin
        en_n++;
        if (en_c < 0) begin en_c = c; addr_s = mem_addr_o; we_s = mem_we_o; wd_s = mem_wdata_o; end
      end
      if (c == 1) chk({p, "stall_pend"}, 64'(stall_o), 64'd1);
      mem_ack_i = (en_c >= 0) && (c == en_c + t.lat);
      if (if_ack_o | dm_ack_o) begin
        ack_c = c; got_dm = dm_ack_o; err_s = err_o; stall_s = stall_o;
        rd_s = dm_ack_o ? dm_rdata_o : if_rdata_o;
        break;
      end
    end
    if_req_i = 0; dm_req_i = 0;
    @(posedge clk_i); #1;
    chk({p, "single_pulse"}, 64'({if_ack_o, dm_ack_o, err_o, mem_en_o}), 64'd0);
    mem_ack_i = 0;
    if (ack_c < 0) chk({p, "ack_seen"}, 64'd0, 64'd1);
    else begin
      chk({p, "port"},    64'(got_dm),  64'(t.is_dm));
      chk({p, "latency"}, 64'(ack_c),   64'(t.exp_cyc));
      chk({p, "rdata"},   64'(rd_s),    64'(t.exp_rd));
      chk({p, "err"},     64'(err_s),   64'(t.exp_err));
      chk({p, "mem_addr"},64'(addr_s),  64'(t.addr));
      chk({p, "mem_we"},  64'(we_s),    64'(t.we));
      chk({p, "en_once"}, 64'(en_n),    64'd1);
      chk({p, "stall_ack"}, 64'(stall_s), 64'd0);
      if (t.we) chk({p, "mem_wdata"}, 64'(wd_s), 64'(t.wdata));
    end
  endtask

  // Both ports held; each requester drops its req for the cycle after its ack.
  task automatic run_pair(input int if_n, input int dm_n, input int n_acks);
    int if_left, dm_left;
    logic if_d, dm_d, en_d;
    if_left = if_n; dm_left = dm_n; if_d = 0; dm_d = 0; en_d = 0;
    order_q.delete();
    dm_we_i = 0; dm_addr_i = 32'h500; if_addr_i = 32'h600;
    if_req_i = (if_left > 0); dm_req_i = (dm_left > 0);
    for (int c = 0; c < 80 && order_q.size() < n_acks; c++) begin
      @(posedge clk_i); #1;
      mem_ack_i = en_d; mem_rdata_i = mem_addr_o + 32'd1; en_d = mem_en_o;
      if (dm_ack_o) begin order_q.push_back(1); dm_left--; end
      if (if_ack_o) begin order_q.push_back(0); if_left--; end
      dm_req_i = (dm_left > 0) && !dm_d;
      if_req_i = (if_left > 0) && !if_d;
      dm_d = dm_ack_o; if_d = if_ack_o;
    end
    mem_ack_i = 0;
  endtask

  vec_t v[8];
  int exp4;

  initial begin
    //       dm we addr          wdata         lat mrd           cyc exp_rd        err
    v[0] = '{0, 0, 32'h0000_0040, 32'h0,        2, 32'hDEAD_BEEF, 4,  32'hDEAD_BEEF, 0};
    v[1] = '{1, 1, 32'h0000_0100, 32'h1234_5678, 1, 32'hBAD0_BAD0, 3,  32'h0,         0};
    v[2] = '{1, 0, 32'h0000_0200, 32'h0,        1, 32'hCAFE_F00D, 3,  32'hCAFE_F00D, 0};
    v[3] = '{1, 1, 32'h0000_0204, 32'h55AA_55AA, 3, 32'h1111_1111, 5,  32'hCAFE_F00D, 0};
    v[4] = '{0, 0, 32'h0000_0080, 32'h0,        0, 32'h9999_9999, 10, 32'h0,         1};
    v[5] = '{0, 0, 32'h0000_0084, 32'h0,        8, 32'h0BAD_F00D, 10, 32'h0BAD_F00D, 0};
    v[6] = '{1, 0, 32'h0000_0300, 32'h0,        9, 32'h7777_7777, 10, 32'h0,         1};
    v[7] = '{0, 0, 32'h0000_0044, 32'h0,        1, 32'h7654_3210, 3,  32'h7654_3210, 0};

    rst_i = 0; if_req_i = 0; dm_req_i = 0; dm_we_i = 0; mem_ack_i = 0;
    if_addr_i = 0; dm_addr_i = 0; dm_wdata_i = 0; mem_rdata_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_ctrl", 64'({if_ack_o, dm_ack_o, mem_en_o, mem_we_o, err_o, stall_o}), 64'd0);
    chk("reset_data", 64'(if_rdata_o | dm_rdata_o | mem_addr_o | mem_wdata_o), 64'd0);
    rst_i = 1;

    for (int i = 0; i < 8; i++) run_txn(i, v[i]);

    run_pair(1, 2, 3);
    chk("arb_count", 64'(order_q.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("arb_order%0d", i), 64'((i < order_q.size()) ? order_q[i] : 9), 64'((i == 1) ? 0 : 1));
    repeat (3) @(posedge clk_i);
    #1;
    run_pair(1, 1, 1);
    if_req_i = 0; dm_req_i = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp4 = 0;
`else
    exp4 = 1;
`endif
    chk("arb_pair_winner", 64'((order_q.size() > 0) ? order_q[0] : 9), 64'(exp4));
    chk("arb_if_rdata", 64'(if_rdata_o), 64'h601);
    chk("arb_dm_rdata", 64'(dm_rdata_o), 64'h501);
    repeat (3) @(posedge clk_i);
    #1;

    // reset while waiting on memory, then a stray ack
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h700; mem_rdata_i = 32'hFFFF_FFFF;
    repeat (4) @(posedge clk_i);
    #1;
    rst_i = 0;
    #1;
    chk("rst_mid_ctrl", 64'({if_ack_o, dm_ack_o, mem_en_o, mem_we_o, err_o}), 64'd0);
    chk("rst_mid_data", 64'(if_rdata_o | dm_rdata_o | mem_addr_o | mem_wdata_o), 64'd0);
    dm_req_i = 0;
    @(posedge clk_i); #1;
    rst_i = 1; mem_ack_i = 1;
    @(posedge clk_i); #1;
    mem_ack_i = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_stray%0d", i), 64'({if_ack_o, dm_ack_o, mem_en_o, err_o, stall_o}), 64'd0);
      @(posedge clk_i); #1;
    end
    chk("rst_stray_data", 64'(dm_rdata_o | mem_addr_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32, data width of all ports.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles to wait for mem_ack_i (legal range 2..255).
REQ-004 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port if_req_i  input  1  instruction-fetch read request.
REQ-007 SHALL have port if_addr_i  input  ADDR_W  fetch address.
REQ-008 SHALL have port if_rdata_o  output  DATA_W  fetch read data.
REQ-009 SHALL have port if_ack_o  output  1  fetch completion pulse.
REQ-010 SHALL have port dm_req_i  input  1  data-memory request.
REQ-011 SHALL have port dm_we_i  input  1  data request is a write when 1.
REQ-012 SHALL have port dm_addr_i  input  ADDR_W  data address.
REQ-013 SHALL have port dm_wdata_i  input  DATA_W  data write value.
REQ-014 SHALL have port dm_rdata_o  output  DATA_W  data read value.
REQ-015 SHALL have port dm_ack_o  output  1  data completion pulse.
REQ-016 SHALL have ports mem_en_o, mem_we_o (output 1), mem_addr_o (output ADDR_W), mem_wdata_o (output DATA_W): shared backing-memory command.
REQ-017 SHALL have ports mem_rdata_i (input DATA_W) and mem_ack_i (input 1): backing-memory response.
REQ-018 SHALL have port stall_o  output  1  pipeline stall, high while any request is pending and not yet acked.
REQ-019 SHALL have port err_o  output  1  one-cycle pulse on timeout.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: on any req, latch winner's we/addr/wdata, go ISSUE next cycle; no req, stay IDLE.
REQ-022 ISSUE: mem_en_o=1 for exactly one cycle with latched command, then WAIT.
REQ-023 WAIT: count cycles from 1; on mem_ack_i latch mem_rdata_i, go RESP; at count==TIMEOUT without ack, latch 0 as read data, pulse err_o, go RESP.
REQ-024 RESP: pulse winner's ack for one cycle with latched rdata (held until next ack of that port), return IDLE.
REQ-025 Minimum request-to-ack latency SHALL be 3 cycles plus memory latency; ack appears the cycle after mem_ack_i registered.
REQ-026 Requesters SHALL hold req and command stable until ack; arbiter uses only latched command after IDLE.
REQ-027 A req deasserted mid-transaction SHALL NOT abort it; memory access completes and ack still pulses.
REQ-028 mem_ack_i outside WAIT SHALL be ignored.
REQ-029 Write transactions SHALL return dm_rdata_o unchanged.
REQ-030 stall_o SHALL be combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
REQ-031 In IDLE with both reqs in same cycle, winner per REQ-036/037; loser remains pending and is served next.

Reset
REQ-032 rst_i low SHALL immediately force IDLE, counter 0, all ack/err/mem_en_o/mem_we_o 0, all data/address outputs 0, round-robin pointer to data port.
REQ-033 Reset mid-transaction SHALL abandon it with no ack; a later mem_ack_i is ignored per REQ-028.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-035 Round-robin pointer SHALL exist only when the macro is defined.
REQ-036 Without ARB_ROUND_ROBIN_EN: fixed priority, data port always wins simultaneous requests.
REQ-037 With ARB_ROUND_ROBIN_EN: on simultaneous requests the port not granted last wins; pointer updates at each grant.

Verification
REQ-038 Fetch only, addr 0x40, mem_ack_i 2 cycles after mem_en_o, rdata 0xDEADBEEF -> if_ack_o pulse, if_rdata_o=0xDEADBEEF, err_o 0.
REQ-039 Data write addr 0x100 wdata 0x12345678 -> mem_we_o=1, mem_addr_o=0x100 for one cycle, dm_ack_o pulse, dm_rdata_o unchanged.
REQ-040 Both reqs held 3 transactions, no macro -> order DM, IF, DM; with macro -> DM, IF, DM then IF after another simultaneous pair.
REQ-041 mem_ack_i never asserted, TIMEOUT=8 -> err_o and ack pulse 8 WAIT cycles after issue, rdata 0.
REQ-042 rst_i low during WAIT, then stray mem_ack_i -> no ack, FSM in IDLE, outputs 0.
